// File: rtl/master_port.sv
// Bus-side master port: serializes one device read/write request MSB-first onto
// the one-bit system bus, deserializes read data, and aborts any stalled wait.
module master_port #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dev_valid,
  output logic                  dev_ready,
  input  logic                  dev_mode,
  input  logic [ADDR_WIDTH-1:0] dev_addr,
  input  logic [DATA_WIDTH-1:0] dev_wdata,
  output logic                  dev_done,
  output logic                  dev_err,
  output logic [DATA_WIDTH-1:0] dev_rdata,
  output logic                  mode,
  output logic                  wr_bus,
  output logic                  master_valid,
  output logic                  master_ready,
  input  logic                  slave_ready,
  input  logic                  slave_valid,
  input  logic                  rd_bus
);
  localparam int unsigned SW  = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned BCW = $clog2(SW + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT + 1);

  localparam logic [BCW-1:0] LAST_ADDR  = BCW'(ADDR_WIDTH - 1);
  localparam logic [BCW-1:0] LAST_WDATA = BCW'(SW - 1);
  localparam logic [BCW-1:0] LAST_RDATA = BCW'(DATA_WIDTH - 1);
  localparam logic [TCW-1:0] LAST_WAIT  = TCW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RWAIT, RDATA, DONE} state_t;

  state_t                state_q;
  logic [SW-1:0]         shreg_q;
  logic [DATA_WIDTH-1:0] rdsh_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [BCW-1:0]        bitcnt_q;
  logic [TCW-1:0]        tocnt_q;
  logic                  mode_q;
  logic                  mvalid_q;
  logic                  mready_q;
  logic                  done_q;
  logic                  err_q;
  logic                  ready_q;

  logic [DATA_WIDTH-1:0] rdsh_d;
  logic                  wait_expired;

  always_comb begin
    rdsh_d       = (rdsh_q << 1) | DATA_WIDTH'(rd_bus);
    wait_expired = (tocnt_q == LAST_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      rdsh_q   <= '0;
      rdata_q  <= '0;
      bitcnt_q <= '0;
      tocnt_q  <= '0;
      mode_q   <= 1'b0;
      mvalid_q <= 1'b0;
      mready_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (dev_valid) begin
            state_q  <= ADDR;
            shreg_q  <= {dev_addr, dev_wdata};
            mode_q   <= dev_mode;
            bitcnt_q <= '0;
            tocnt_q  <= '0;
            mvalid_q <= 1'b1;
            ready_q  <= 1'b0;
          end
        end
        ADDR, WDATA: begin
          // master_valid is always high here, so slave_ready alone marks a transfer
          if (slave_ready) begin
            shreg_q  <= shreg_q << 1;
            bitcnt_q <= bitcnt_q + 1'b1;
            tocnt_q  <= '0;
            if (state_q == ADDR && bitcnt_q == LAST_ADDR) begin
              if (mode_q) begin
                state_q <= WDATA;
              end else begin
                state_q  <= RWAIT;
                mvalid_q <= 1'b0;
                mready_q <= 1'b1;
                bitcnt_q <= '0;
              end
            end else if (state_q == WDATA && bitcnt_q == LAST_WDATA) begin
              state_q  <= DONE;
              mvalid_q <= 1'b0;
              done_q   <= 1'b1;
              err_q    <= 1'b0;
            end
          end else if (wait_expired) begin
            state_q  <= DONE;
            mvalid_q <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= 1'b1;
          end else begin
            tocnt_q <= tocnt_q + 1'b1;
          end
        end
        RWAIT, RDATA: begin
          if (slave_valid) begin
            rdsh_q   <= rdsh_d;
            bitcnt_q <= bitcnt_q + 1'b1;
            tocnt_q  <= '0;
            state_q  <= RDATA;
            if (bitcnt_q == LAST_RDATA) begin
              state_q  <= DONE;
              mready_q <= 1'b0;
              done_q   <= 1'b1;
              err_q    <= 1'b0;
              rdata_q  <= rdsh_d;
            end
          end else if (wait_expired) begin
            state_q  <= DONE;
            mready_q <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= 1'b1;
          end else begin
            tocnt_q <= tocnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dev_ready    = ready_q;
  assign dev_done     = done_q;
  assign dev_err      = err_q;
  assign dev_rdata    = rdata_q;
  assign mode         = mode_q;
  assign wr_bus       = shreg_q[SW-1];
  assign master_valid = mvalid_q;
  assign master_ready = mready_q;

endmodule

// File: tb/tb_master_port.sv
// Self-checking bench for master_port: directed vector table, hand-written
// reset/back-to-back sequences and random transactions against a timing model.
module tb_master_port;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 8;
  localparam int unsigned NB = AW + DW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          dev_valid = 1'b0;
  logic          dev_mode = 1'b0;
  logic [AW-1:0] dev_addr = '0;
  logic [DW-1:0] dev_wdata = '0;
  logic          dev_ready, dev_done, dev_err;
  logic [DW-1:0] dev_rdata;
  logic          mode, wr_bus, master_valid, master_ready;
  logic          slave_ready = 1'b0;
  logic          slave_valid = 1'b0;
  logic          rd_bus = 1'b0;

  int errors = 0;
  int checks = 0;

  int            stall_w[NB];
  int            stall_r[DW];
  logic [DW-1:0] model_rdata;

  always #5 clk = ~clk;

  master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .dev_valid(dev_valid), .dev_ready(dev_ready), .dev_mode(dev_mode),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_done(dev_done), .dev_err(dev_err), .dev_rdata(dev_rdata),
    .mode(mode), .wr_bus(wr_bus), .master_valid(master_valid), .master_ready(master_ready),
    .slave_ready(slave_ready), .slave_valid(slave_valid), .rd_bus(rd_bus)
  );

  typedef struct {
    bit            m;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] sd;
    int            sbit;
    int            slen;
    int            rbit;
    int            rlen;
    int            exp_cyc;
    bit            exp_err;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < int'(NB); i++) stall_w[i] = 0;
    for (int j = 0; j < int'(DW); j++) stall_r[j] = 0;
  endtask

  // Completion time = one edge per bit plus its stall; a stall of TO or more
  // cycles ends the transaction TO edges after the previous transfer.
  function automatic void model(input bit m, output int done_cyc, output bit err, output int nbits);
    int t;
    int n;
    t = 0;
    n = m ? int'(NB) : int'(AW);
    err = 1'b0;
    nbits = 0;
    done_cyc = 0;
    for (int i = 0; i < n; i++) begin
      if (stall_w[i] >= int'(TO)) begin
        done_cyc = t + int'(TO);
        err = 1'b1;
        return;
      end
      t += stall_w[i] + 1;
      nbits++;
    end
    if (!m) begin
      for (int j = 0; j < int'(DW); j++) begin
        if (stall_r[j] >= int'(TO)) begin
          done_cyc = t + int'(TO);
          err = 1'b1;
          return;
        end
        t += stall_r[j] + 1;
      end
    end
    done_cyc = t;
  endfunction

  task automatic run_txn(input string tag, input bit m, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] sd,
                         input bit hold, input int exp_cyc, input bit exp_err);
    int            cyc, wi, ri, wleft, rleft, w, nbits, mcyc;
    bit            merr, mode_bad, rdy_bad, bus_bad;
    logic [NB-1:0] s, got;
    s = {a, wd};
    got = '0;
    wi = 0;
    ri = 0;
    wleft = stall_w[0];
    rleft = stall_r[0];
    mode_bad = 1'b0;
    rdy_bad = 1'b0;
    bus_bad = 1'b0;
    model(m, mcyc, merr, nbits);
    w = 0;
    while (dev_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, " idle_before"}, 32'(dev_ready), 32'd1);
    dev_valid = 1'b1;
    dev_mode = m;
    dev_addr = a;
    dev_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    dev_valid = hold;
    dev_mode = ~m;
    dev_addr = ~a;
    dev_wdata = ~wd;
    check({tag, " accept"}, 32'({dev_ready, master_valid}), 32'b01);
    cyc = 0;
    while (dev_done !== 1'b1 && cyc < 300) begin
      if (mode !== m) mode_bad = 1'b1;
      if (dev_ready !== 1'b0) rdy_bad = 1'b1;
      if (master_valid === 1'b1 && master_ready === 1'b1) bus_bad = 1'b1;
      slave_ready = 1'b0;
      slave_valid = 1'b0;
      rd_bus = 1'b0;
      if (master_valid === 1'b1 && wi < int'(NB)) begin
        if (wr_bus !== s[NB-1-wi]) bus_bad = 1'b1;
        if (wleft > 0) wleft--;
        else begin
          slave_ready = 1'b1;
          got = {got[NB-2:0], wr_bus};
          wi++;
          if (wi < int'(NB)) wleft = stall_w[wi];
        end
      end
      if (master_ready === 1'b1 && ri < int'(DW)) begin
        if (rleft > 0) rleft--;
        else begin
          slave_valid = 1'b1;
          rd_bus = sd[DW-1-ri];
          ri++;
          if (ri < int'(DW)) rleft = stall_r[ri];
        end
      end
      @(negedge clk);
      cyc++;
    end
    slave_ready = 1'b0;
    slave_valid = 1'b0;
    rd_bus = 1'b0;
    if (!m && !exp_err) model_rdata = sd;
    check({tag, " done_seen"}, 32'(dev_done), 32'd1);
    check({tag, " done_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({tag, " err"}, 32'(dev_err), 32'(exp_err));
    check({tag, " bits_sent"}, 32'(wi), 32'(nbits));
    check({tag, " stream"}, 32'(got), 32'(s >> (NB - nbits)));
    check({tag, " rdata"}, 32'(dev_rdata), 32'(model_rdata));
    check({tag, " bus_idle_at_done"}, 32'({master_valid, master_ready}), 32'b00);
    check({tag, " hold_flags"}, 32'({mode_bad, rdy_bad, bus_bad}), 32'b000);
    @(negedge clk);
    check({tag, " ready_after"}, 32'({dev_done, dev_ready}), 32'b01);
  endtask

  initial begin
    int  c, nb;
    bit  e, m, seen;
    int  p;
    logic [AW-1:0] ra;
    logic [DW-1:0] rw, rs;

    tbl[0] = '{1'b1, 16'h1234, 8'hA5, 8'h00, -1, 0, -1, 0,   24, 1'b0};
    tbl[1] = '{1'b0, 16'h0003, 8'h00, 8'h5C, -1, 0,  0, 3,   27, 1'b0};
    tbl[2] = '{1'b1, 16'h1234, 8'hA5, 8'h00,  5, 4, -1, 0,   28, 1'b0};
    tbl[3] = '{1'b0, 16'h00F0, 8'h00, 8'h77, -1, 0,  0, 100, 24, 1'b1};
    tbl[4] = '{1'b1, 16'hBEEF, 8'h3C, 8'h00,  2, 9, -1, 0,   10, 1'b1};
    tbl[5] = '{1'b1, 16'h0000, 8'hFF, 8'h00, 23, 7, -1, 0,   31, 1'b0};
    tbl[6] = '{1'b0, 16'hFFFF, 8'h00, 8'hA3, -1, 0,  4, 7,   31, 1'b0};
    tbl[7] = '{1'b0, 16'h8001, 8'h00, 8'h01, -1, 0,  5, 8,   29, 1'b1};
    tbl[8] = '{1'b1, 16'h8000, 8'h01, 8'h00,  0, 8, -1, 0,    8, 1'b1};
    tbl[9] = '{1'b0, 16'h5A5A, 8'h00, 8'hC3, 15, 2, -1, 0,   26, 1'b0};

    model_rdata = '0;
    clear_stalls();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dev", 32'({dev_ready, dev_done, dev_err, dev_rdata}), 32'h400);
    check("reset_bus", 32'({mode, wr_bus, master_valid, master_ready}), 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 10; k++) begin
      clear_stalls();
      if (tbl[k].sbit >= 0) stall_w[tbl[k].sbit] = tbl[k].slen;
      if (tbl[k].rbit >= 0) stall_r[tbl[k].rbit] = tbl[k].rlen;
      run_txn($sformatf("vec%0d", k), tbl[k].m, tbl[k].a, tbl[k].wd, tbl[k].sd, 1'b0,
              tbl[k].exp_cyc, tbl[k].exp_err);
    end

    // reset in the middle of the write-data phase
    clear_stalls();
    dev_valid = 1'b1;
    dev_mode = 1'b1;
    dev_addr = 16'hC0DE;
    dev_wdata = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    dev_valid = 1'b0;
    for (int k = 0; k < 19; k++) begin
      slave_ready = 1'b1;
      @(negedge clk);
    end
    check("rst_pre_wdata_bit3", 32'(wr_bus), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    slave_ready = 1'b0;
    model_rdata = '0;
    check("rst_bus_outputs", 32'({master_valid, master_ready, wr_bus, mode}), 32'h0);
    check("rst_dev_outputs", 32'({dev_done, dev_ready, dev_rdata}), 32'h100);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (dev_done === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    check("rst_no_done", 32'(seen), 32'd0);
    run_txn("post_rst_write", 1'b1, 16'hC0DE, 8'h5A, 8'h00, 1'b0, 24, 1'b0);

    // dev_valid held high across back-to-back requests
    clear_stalls();
    run_txn("b2b0", 1'b1, 16'h0F0F, 8'h81, 8'h00, 1'b1, 24, 1'b0);
    run_txn("b2b1", 1'b0, 16'hA001, 8'h00, 8'h96, 1'b1, 24, 1'b0);
    run_txn("b2b2", 1'b1, 16'h7FFE, 8'h18, 8'h00, 1'b1, 24, 1'b0);
    dev_valid = 1'b0;

    for (int n = 0; n < 40; n++) begin
      m  = 1'($urandom_range(0, 1));
      ra = AW'($urandom);
      rw = DW'($urandom);
      rs = DW'($urandom);
      clear_stalls();
      for (int i = 0; i < int'(NB); i++)
        if ($urandom_range(0, 7) == 0) stall_w[i] = int'($urandom_range(1, 5));
      for (int j = 0; j < int'(DW); j++)
        if ($urandom_range(0, 5) == 0) stall_r[j] = int'($urandom_range(1, 6));
      if ($urandom_range(0, 7) == 0) begin
        p = int'($urandom_range(0, NB - 1));
        if (m || p < int'(AW)) stall_w[p] = int'(TO) + int'($urandom_range(0, 2));
        else stall_r[p - int'(AW)] = int'(TO) + int'($urandom_range(0, 2));
      end
      model(m, c, e, nb);
      run_txn($sformatf("rand%0d", n), m, ra, rw, rs, 1'b0, c, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
